fp32_mul: RTL and testbench
===========================

Name: fp32_mul

Overview:
- Synthesizable FP32 multiplier (y = a*b) with a fixed 3-stage pipeline.
- Sits directly upstream of the FP32 adder in each systolic-array PE and produces the products the adder accumulates.
- Arithmetic conventions match the adder: normals and ±0 supported, subnormals flushed to zero, truncate rounding, overflow saturates to ±Inf.
- Adds a pipeline-wide hold (stall) and a sideband tag passthrough.

Parameters:
- TAG_W, 8: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  when 1, every pipeline register, including valids and tags, keeps its value.
- valid_in  in  1  a, b, tag_in are valid this cycle; sampled only when hold=0.
- a  in  32  FP32 operand A.
- b  in  32  FP32 operand B.
- tag_in  in  TAG_W  sideband tag.
- valid_out  out  1  y and tag_out are valid.
- y  out  32  FP32 product.
- tag_out  out  TAG_W  tag delivered with its product.

Behaviour:
- Reset: one clock, synchronous, active-high. On a clk edge with rst=1, all stage valids, y and tag_out go to 0; rst overrides hold. In-flight operations are discarded. valid_out=0 in the cycle after reset is sampled.
- Latency: exactly 3 enabled cycles (edges with hold=0) from valid_in to valid_out. Throughput is one operation per enabled cycle. Order is preserved.
- Hold: while hold=1, nothing advances or is dropped. Outputs stay constant, so a held valid_out=1 presents the same y/tag_out. Bubbles (valid=0) advance like data.
- Stage 1:
  - sign = a[31]^b[31].
  - zero flag = (a[30:23]==0) | (b[30:23]==0).
  - mantissas {1,frac}, 24 bits each.
  - biased exponent sum e = a_e + b_e - 127, held as 10-bit signed (range -127..383).
- Stage 2: 48-bit unsigned product p = ma*mb. Sign, e, zero flag and tag are piped alongside.
- Stage 3, normalise and pack:
  - if p[47]=1: frac = p[46:24], e = e+1; else frac = p[45:23].
  - zero flag set -> y = {sign, 31'h0}.
  - else e >= 255 -> y = {sign, 8'hFF, 23'h0}.
  - else e <= 0 -> y = {sign, 31'h0} (underflow flush).
  - else y = {sign, e[7:0], frac}. No rounding; discarded bits are truncated.
- Zero always carries the XOR sign (-x*0 = -0).
- Without the optional feature, exponent 255 inputs are treated as ordinary normals and feed the same arithmetic, so the result typically saturates to ±Inf.
- valid_out=0 does not gate y; y holds the last stage-3 value computed from whatever occupies stage 2.

Optional Feature:
- Macro: FP32_MUL_NAN_EN.
- When defined, stage 1 adds special-case detection, applied at stage 3 ahead of all other rules:
  - either operand NaN (exp=FF, frac!=0) -> y = 32'h7FC00000.
  - Inf * zero/subnormal -> y = 32'h7FC00000.
  - Inf * finite nonzero or Inf * Inf -> y = {sign, 8'hFF, 23'h0}.
- Latency is unchanged.
- When not defined, no special-case logic is present and behaviour is exactly as above.

Test Plan:
- a=40400000 (3.0), b=40000000 (2.0), tag=0x11, hold=0 -> valid_out=1 exactly 3 cycles later, y=40C00000, tag_out=0x11.
- a=3FC00000, b=3FC00000 (1.5*1.5, p[47] path) -> y=40100000. Then a=C0000000, b=00000000 -> y=80000000. Then a=00400000 (subnormal), b=3F800000 -> y=00000000.
- a=b=7F000000 -> y=7F800000. a=b=00800000 -> y=00000000. a=FF000000, b=40000000 -> y=FF800000.
- Four back-to-back valids (tags 1..4) with hold=1 asserted for 2 cycles after the second issue -> outputs appear in order 1..4, each 3 enabled cycles after issue. y/valid_out are frozen during hold; no loss, no duplication.
- Pipeline full (3 valids in flight), rst=1 for one cycle -> valid_out=0, y=0, tag_out=0 from the next cycle; no in-flight result ever appears.
- With FP32_MUL_NAN_EN: a=7F800000, b=00000000 -> y=7FC00000; a=7FC00001, b=3F800000 -> y=7FC00000; a=FF800000, b=C0000000 -> y=7F800000. Without the macro, a=7F800000, b=3F800000 -> y=7F800000.

Source files
------------

// File: rtl/fp32_mul_if.sv
// Handshake/data bundle for the FP32 multiplier: operands, tag and hold in; product, tag and valid out.
interface fp32_mul_if #(
  parameter int TAG_W = 8
) ();
  logic             hold;
  logic             valid_in;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [TAG_W-1:0] tag_in;
  logic             valid_out;
  logic [31:0]      y;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output hold, valid_in, a, b, tag_in,
    input  valid_out, y, tag_out
  );

  modport slave (
    input  hold, valid_in, a, b, tag_in,
    output valid_out, y, tag_out
  );
endinterface

// File: rtl/fp32_mul.sv
// FP32 multiplier, 3-stage pipeline with global hold and tag passthrough; FTZ, truncation, saturate to Inf.
// Define FP32_MUL_NAN_EN to add NaN/Inf special-case handling (same latency).
module fp32_mul #(
  parameter int TAG_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  fp32_mul_if.slave     bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Stage 1: unpacked operands
  logic                s1_valid;
  logic                s1_sign;
  logic                s1_zero;
  logic [23:0]         s1_ma;
  logic [23:0]         s1_mb;
  logic signed [9:0]   s1_e;
  logic [TAG_W-1:0]    s1_tag;

  // Stage 2: product; only bits [47:23] are ever needed for normalisation
  logic                s2_valid;
  logic                s2_sign;
  logic                s2_zero;
  logic [24:0]         s2_p;
  logic signed [9:0]   s2_e;
  logic [TAG_W-1:0]    s2_tag;

  // Stage 3: output registers
  logic                valid_q;
  logic [31:0]         y_q;
  logic [TAG_W-1:0]    tag_q;

`ifdef FP32_MUL_NAN_EN
  logic s1_nan, s1_inf;
  logic s2_nan, s2_inf;
  logic a_inf, b_inf, a_nan, b_nan, a_ez, b_ez;

  assign a_ez  = (bus.a[30:23] == 8'h00);
  assign b_ez  = (bus.b[30:23] == 8'h00);
  assign a_inf = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'h0);
  assign b_inf = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] == 23'h0);
  assign a_nan = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'h0);
  assign b_nan = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] != 23'h0);
`endif

  logic signed [9:0] e_sum;
  assign e_sum = $signed({2'b00, bus.a[30:23]}) + $signed({2'b00, bus.b[30:23]}) - 10'sd127;

  logic signed [9:0] e_norm;
  logic [22:0]       frac;
  logic [31:0]       y_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    e_norm = s2_e;
    frac   = s2_p[22:0];
    if (s2_p[24]) begin
      e_norm = s2_e + 10'sd1;
      frac   = s2_p[23:1];
    end
    y_next = {s2_sign, e_norm[7:0], frac};
`ifdef FP32_MUL_NAN_EN
    if (s2_nan)
      y_next = QNAN;
    else if (s2_inf)
      y_next = {s2_sign, 8'hFF, 23'h0};
    else
`endif
    if (s2_zero)
      y_next = {s2_sign, 31'h0};
    else if (e_norm >= 10'sd255)
      y_next = {s2_sign, 8'hFF, 23'h0};
    else if (e_norm <= 10'sd0)
      y_next = {s2_sign, 31'h0};
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      valid_q  <= 1'b0;
      y_q      <= 32'h0;
      tag_q    <= '0;
    end else if (!bus.hold) begin
      s1_valid <= bus.valid_in;
      s2_valid <= s1_valid;
      valid_q  <= s2_valid;
      y_q      <= y_next;
      tag_q    <= s2_tag;
    end
  end

  // NOTE: datapath registers are not reset; their contents are only observed behind a valid.
  always_ff @(posedge clk) begin
    if (!bus.hold) begin
      s1_sign <= bus.a[31] ^ bus.b[31];
      s1_zero <= (bus.a[30:23] == 8'h00) || (bus.b[30:23] == 8'h00);
      s1_ma   <= {1'b1, bus.a[22:0]};
      s1_mb   <= {1'b1, bus.b[22:0]};
      s1_e    <= e_sum;
      s1_tag  <= bus.tag_in;
`ifdef FP32_MUL_NAN_EN
      s1_nan  <= a_nan || b_nan || (a_inf && b_ez) || (b_inf && a_ez);
      s1_inf  <= a_inf || b_inf;
      s2_nan  <= s1_nan;
      s2_inf  <= s1_inf;
`endif
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_p    <= 25'(({24'h0, s1_ma} * {24'h0, s1_mb}) >> 23);
      s2_e    <= s1_e;
      s2_tag  <= s1_tag;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.y         = y_q;
  assign bus.tag_out   = tag_q;

endmodule

// File: tb/tb_fp32_mul.sv
// Self-checking bench for fp32_mul: value model + enabled-cycle latency scoreboard, directed and random stimulus.
module tb_fp32_mul;
  localparam int TAG_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp32_mul_if #(.TAG_W(TAG_W)) bus ();
  fp32_mul #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value model: straight from the arithmetic rules, no notion of pipeline stages.
  function automatic logic [31:0] model_mul(input logic [31:0] x, input logic [31:0] z);
    logic        s;
    int          ex, ez, e;
    logic [47:0] p;
    logic [22:0] f;
    s  = x[31] ^ z[31];
    ex = int'(x[30:23]);
    ez = int'(z[30:23]);
`ifdef FP32_MUL_NAN_EN
    if ((ex == 255 && x[22:0] != 0) || (ez == 255 && z[22:0] != 0)) return 32'h7FC00000;
    if (ex == 255 || ez == 255) return (ex == 0 || ez == 0) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
`endif
    if (ex == 0 || ez == 0) return {s, 31'h0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, z[22:0]});
    e = ex + ez - 127;
    if (p >= 48'h8000_0000_0000) begin
      e++;
      f = p[46:24];
    end else begin
      f = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'h00;
      1: e = 8'hFF;
      2: begin e = 8'hFF; f = 23'h0; end
      3: e = 8'($urandom_range(1, 20));
      4: e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  typedef enum {E_NONE, E_RST, E_HOLD, E_EN} edge_t;

  exp_t             q[$];
  edge_t            last_edge = E_NONE;
  int               en_count  = 0;
  logic             prev_valid;
  logic [31:0]      prev_y;
  logic [TAG_W-1:0] prev_tag;

  // Scoreboard: classify each edge, enqueue accepted operations with their due enabled-edge index.
  always @(posedge clk) begin
    if (rst) begin
      last_edge = E_RST;
      q.delete();
    end else if (bus.hold) begin
      last_edge = E_HOLD;
    end else begin
      en_count++;
      last_edge = E_EN;
      if (bus.valid_in)
        q.push_back('{model_mul(bus.a, bus.b), bus.tag_in, en_count + 2});
    end
  end

  // Compare on the falling edge, every cycle.
  always @(negedge clk) begin
    case (last_edge)
      E_RST: begin
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_y", bus.y, 32'h0);
        check("rst_tag", 32'(bus.tag_out), 32'h0);
      end
      E_HOLD: begin
        check("hold_valid", 32'(bus.valid_out), 32'(prev_valid));
        check("hold_y", bus.y, prev_y);
        check("hold_tag", 32'(bus.tag_out), 32'(prev_tag));
      end
      E_EN: begin
        if (q.size() > 0 && q[0].due == en_count) begin
          check("out_valid", 32'(bus.valid_out), 32'd1);
          check("out_y", bus.y, q[0].y);
          check("out_tag", 32'(bus.tag_out), 32'(q[0].tag));
          void'(q.pop_front());
        end else begin
          check("idle_valid", 32'(bus.valid_out), 32'd0);
        end
      end
      default: ;
    endcase
    prev_valid = bus.valid_out;
    prev_y     = bus.y;
    prev_tag   = bus.tag_out;
  end

  task automatic drive(input bit v, input logic [31:0] av, input logic [31:0] bv,
                       input logic [TAG_W-1:0] t, input bit h);
    bus.valid_in = v;
    bus.a        = av;
    bus.b        = bv;
    bus.tag_in   = t;
    bus.hold     = h;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, '0, 1'b0);
  endtask

  logic [31:0] dir_a [8] = '{32'h40400000, 32'h3FC00000, 32'hC0000000, 32'h00400000,
                             32'h7F000000, 32'h00800000, 32'hFF000000, 32'h7F800000};
  logic [31:0] dir_b [8] = '{32'h40000000, 32'h3FC00000, 32'h00000000, 32'h3F800000,
                             32'h7F000000, 32'h00800000, 32'h40000000, 32'h3F800000};

  initial begin
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.a = '0; bus.b = '0; bus.tag_in = '0; bus.hold = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-computed values that pin the model.
    check("pin_3x2", model_mul(32'h40400000, 32'h40000000), 32'h40C00000);
    check("pin_1p5sq", model_mul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
    check("pin_neg0", model_mul(32'hC0000000, 32'h00000000), 32'h80000000);
    check("pin_sub", model_mul(32'h00400000, 32'h3F800000), 32'h00000000);
    check("pin_ovf", model_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
    check("pin_unf", model_mul(32'h00800000, 32'h00800000), 32'h00000000);
    check("pin_novf", model_mul(32'hFF000000, 32'h40000000), 32'hFF800000);
`ifdef FP32_MUL_NAN_EN
    check("pin_inf0", model_mul(32'h7F800000, 32'h00000000), 32'h7FC00000);
    check("pin_nan", model_mul(32'h7FC00001, 32'h3F800000), 32'h7FC00000);
    check("pin_infinf", model_mul(32'hFF800000, 32'hC0000000), 32'h7F800000);
`else
    check("pin_inf1", model_mul(32'h7F800000, 32'h3F800000), 32'h7F800000);
`endif

    // Directed vectors back to back.
    for (int i = 0; i < 8; i++) drive(1'b1, dir_a[i], dir_b[i], TAG_W'(8'h11 + i), 1'b0);
    idle(4);

    // Hold for two cycles after the second issue.
    drive(1'b1, 32'h40400000, 32'h3F800000, 8'd1, 1'b0);
    drive(1'b1, 32'h40000000, 32'h40000000, 8'd2, 1'b0);
    drive(1'b1, 32'h41000000, 32'h3F000000, 8'hEE, 1'b1);
    drive(1'b1, 32'h41000000, 32'h3F000000, 8'hEE, 1'b1);
    drive(1'b1, 32'hC0400000, 32'h40400000, 8'd3, 1'b0);
    drive(1'b1, 32'h3F800001, 32'h3F800001, 8'd4, 1'b0);
    drive(1'b0, 32'h0, 32'h0, '0, 1'b1);
    idle(4);

    // Full pipeline then reset (with hold also high, reset must win).
    drive(1'b1, 32'h40400000, 32'h40000000, 8'hA1, 1'b0);
    drive(1'b1, 32'h40400000, 32'h40400000, 8'hA2, 1'b0);
    drive(1'b1, 32'h40800000, 32'h40000000, 8'hA3, 1'b0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, '0, 1'b1);
    rst = 1'b0;
    idle(5);

    // Random traffic with random holds.
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 3) != 0, rand_fp(), rand_fp(), TAG_W'($urandom), $urandom_range(0, 4) == 0);

    idle(6);
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
